sha_stream_ctrl: RTL and testbench

SHA_STREAM_CTRL -- requirements
Module: sha_stream_ctrl

---
 rtl/sha_ctrl_pkg.sv | 25 ++
 rtl/sha_stream_ctrl_if.sv | 11 +
 rtl/sha_pad_word.sv | 21 ++
 rtl/sha_stream_ctrl.sv | 122 ++++++++++++
 tb/tb_sha_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_ctrl_pkg.sv
// sha_ctrl_pkg: register map, control codes and FSM encoding for the SHA-256 stream controller
package sha_ctrl_pkg;
  localparam logic [7:0] ADDR_CTRL = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0 = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;
  localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
  localparam logic [31:0] CTRL_NEXT = 32'h0000_0002;
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;
  localparam logic [31:0] PAD_MARK = 32'h8000_0000;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD = 3'd2,
    START = 3'd3,
    WAIT = 3'd4,
    POLL = 3'd5,
    READ = 3'd6,
    DONE = 3'd7
  } state_e;
  function automatic logic [63:0] bit_length(input logic [31:0] words);
    return {27'd0, words, 5'd0};
  endfunction
endpackage

// File: rtl/sha_stream_ctrl_if.sv
// sha_stream_ctrl_if: register bus between the stream controller (master) and the sha256 core (slave)
interface sha_stream_ctrl_if;
  logic sha_cs;
  logic sha_we;
  logic [7:0] sha_address;
  logic [31:0] sha_write_data;
  logic [31:0] sha_read_data;
  logic sha_error;
  modport master(output sha_cs, sha_we, sha_address, sha_write_data, input sha_read_data, sha_error);
  modport slave(input sha_cs, sha_we, sha_address, sha_write_data, output sha_read_data, sha_error);
endinterface

// File: rtl/sha_pad_word.sv
// sha_pad_word: padding word for a block slot, given where the message ended and whether this is the spill block
module sha_pad_word
  import sha_ctrl_pkg::*;
(
  input logic [3:0] slot,
  input logic [3:0] last_slot,
  input logic [31:0] word_count,
  input logic spill,
  output logic [31:0] word
);
  logic [63:0] len;
  logic has_len;
  logic mark;
  assign len = bit_length(word_count);
  // the length only fits in the message's own block when it ended before slot 13
  assign has_len = spill || last_slot < 4'd13;
  assign mark = spill ? slot == 4'd0 && last_slot == 4'd15 : slot == last_slot + 4'd1;
  assign word = slot == 4'd14 && has_len ? len[63:32] :
                slot == 4'd15 && has_len ? len[31:0] :
                mark ? PAD_MARK : 32'd0;
endmodule

// File: rtl/sha_stream_ctrl.sv
// sha_stream_ctrl: streams message words into a sha256 register-bus core, pads, runs blocks and reads the digest
module sha_stream_ctrl
  import sha_ctrl_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024
) (
  input logic clk,
  input logic reset_n,
  input logic in_valid,
  input logic [31:0] in_data,
  input logic in_last,
  output logic in_ready,
  output logic [255:0] digest,
  output logic digest_valid,
  output logic busy,
  output logic error,
  sha_stream_ctrl_if.master sha
);
  state_e state;
  logic [3:0] slot, last_slot;
  logic [31:0] word_count, polls, pad;
  logic first, msg_end, spill, accept, final_blk;
  assign in_ready = reset_n && (state == IDLE || state == LOAD);
  assign accept = in_valid && in_ready;
  assign final_blk = msg_end && (spill || last_slot < 4'd13);
  assign busy = state != IDLE && state != DONE;
  assign digest_valid = state == DONE;
  sha_pad_word u_pad (.slot, .last_slot, .word_count, .spill, .word(pad));
  always_comb begin
    sha.sha_cs = 1'b0;
    sha.sha_we = 1'b0;
    sha.sha_address = 8'd0;
    sha.sha_write_data = 32'd0;
    case (state)
      IDLE, LOAD: begin
        sha.sha_cs = accept;
        sha.sha_we = accept;
        sha.sha_address = accept ? ADDR_BLOCK0 + {4'd0, slot} : 8'd0;
        sha.sha_write_data = accept ? in_data : 32'd0;
      end
      PAD: begin
        sha.sha_cs = 1'b1;
        sha.sha_we = 1'b1;
        sha.sha_address = ADDR_BLOCK0 + {4'd0, slot};
        sha.sha_write_data = pad;
      end
      START: begin
        sha.sha_cs = 1'b1;
        sha.sha_we = 1'b1;
        sha.sha_address = ADDR_CTRL;
        sha.sha_write_data = first ? CTRL_INIT : CTRL_NEXT;
      end
      POLL: begin
        sha.sha_cs = 1'b1;
        sha.sha_address = ADDR_STATUS;
      end
      READ: begin
        sha.sha_cs = 1'b1;
        sha.sha_address = ADDR_DIGEST0 + {4'd0, slot};
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      slot <= '0;
      last_slot <= '0;
      word_count <= '0;
      polls <= '0;
      first <= 1'b0;
      msg_end <= 1'b0;
      spill <= 1'b0;
      error <= 1'b0;
      digest <= '0;
    end else if (sha.sha_cs && sha.sha_error) begin
      state <= IDLE;
      slot <= '0;
      error <= 1'b1;
    end else
      case (state)
        IDLE, LOAD: if (accept) begin
          if (state == IDLE) begin
            first <= 1'b1;
            spill <= 1'b0;
            error <= 1'b0;
          end
          word_count <= state == IDLE ? 32'd1 : word_count + 32'd1;
          msg_end <= in_last;
          last_slot <= slot;
          slot <= slot + 4'd1;
          state <= slot == 4'd15 ? START : in_last ? PAD : LOAD;
        end
        PAD: begin
          slot <= slot + 4'd1;
          if (slot == 4'd15) state <= START;
        end
        START: begin
          first <= 1'b0;
          polls <= '0;
          state <= WAIT;
        end
        WAIT: state <= POLL;
        POLL: if (sha.sha_read_data[STATUS_READY_BIT]) begin
          spill <= msg_end && !final_blk;
          state <= !msg_end ? LOAD : final_blk ? READ : PAD;
        end else if (polls == 32'(POLL_TIMEOUT - 1)) begin
          error <= 1'b1;
          state <= IDLE;
        end else polls <= polls + 32'd1;
        // words arrive 0..7, so shifting in leaves word 0 at the top
        READ: begin
          digest <= {digest[223:0], sha.sha_read_data};
          slot <= slot + 4'd1;
          if (slot == 4'd7) begin
            slot <= '0;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sha_stream_ctrl.sv
// tb_sha_stream_ctrl: drives messages through the controller into a behavioural sha256 core and checks
// block contents, control writes and digests against a word-level SHA-256 reference
module tb_sha_stream_ctrl;
  typedef logic [31:0] wq_t[$];
  typedef struct {
    int len;
    logic [31:0] base;
    int blocks;
    logic [31:0] slot0;
    logic [31:0] slot15;
  } vec_t;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABCD_DIGEST = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic in_last = 1'b0;
  logic in_ready, digest_valid, busy, error;
  logic [255:0] digest;
  int tests = 0;
  int fails = 0;
  sha_stream_ctrl_if bus ();
  sha_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .digest(digest), .digest_valid(digest_valid), .busy(busy), .error(error), .sha(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction
  // message words -> padded word stream: marker, zeros to 14 mod 16, 64-bit bit count
  function automatic wq_t ref_pad(input wq_t m);
    wq_t p;
    logic [63:0] bits;
    p = m;
    bits = 64'(m.size()) * 64'd32;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'd0);
    p.push_back(bits[63:32]);
    p.push_back(bits[31:0]);
    return p;
  endfunction
  function automatic logic [511:0] ref_block(input wq_t p, input int k);
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = p[16*k + j];
    return b;
  endfunction
  function automatic logic [255:0] ref_digest(input wq_t p);
    logic [255:0] h;
    h = IV;
    for (int k = 0; k < p.size() / 16; k++) h = sha_compress(h, ref_block(p, k));
    return h;
  endfunction
  logic [511:0] blk = '0;
  logic [255:0] h_state = '0;
  int lat = 0;
  int poll_cnt = 0;
  int dv_cnt = 0;
  logic hold_busy = 1'b0;
  logic err_en = 1'b0;
  logic [31:0] ctrl_log[$];
  logic [511:0] blk_log[$];
  assign bus.sha_error = err_en && bus.sha_cs && bus.sha_we && bus.sha_address == 8'h13;
  always_comb begin
    bus.sha_read_data = 32'd0;
    if (bus.sha_cs && !bus.sha_we && bus.sha_address == 8'h09)
      bus.sha_read_data = {30'd0, 1'b1, lat == 0 && !hold_busy};
    else if (bus.sha_cs && !bus.sha_we && bus.sha_address[7:3] == 5'b00100)
      bus.sha_read_data = h_state[255 - 32*int'(bus.sha_address[2:0]) -: 32];
  end
  always @(posedge clk) begin
    if (lat > 0) lat <= lat - 1;
    if (bus.sha_cs && bus.sha_we && bus.sha_address[7:4] == 4'h1)
      blk[511 - 32*int'(bus.sha_address[3:0]) -: 32] <= bus.sha_write_data;
    if (bus.sha_cs && bus.sha_we && bus.sha_address == 8'h08) begin
      ctrl_log.push_back(bus.sha_write_data);
      blk_log.push_back(blk);
      h_state <= sha_compress(bus.sha_write_data == 32'h1 ? IV : h_state, blk);
      lat <= $urandom_range(1, 6);
    end
    if (bus.sha_cs && !bus.sha_we && bus.sha_address == 8'h09) poll_cnt <= poll_cnt + 1;
    if (digest_valid) dv_cnt <= dv_cnt + 1;
  end
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send_msg(input wq_t m, input int gap, input bit mark_last);
    int t;
    for (int i = 0; i < m.size(); i++) begin
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = $urandom;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      in_valid = 1'b1;
      in_data = m[i];
      in_last = mark_last && i == m.size() - 1;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check("in_ready_wait", in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic run_msg(input wq_t m, input int gap);
    wq_t p;
    int c0, nb, t;
    p = ref_pad(m);
    nb = p.size() / 16;
    c0 = ctrl_log.size();
    send_msg(m, gap, 1'b1);
    t = 0;
    while (!digest_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("digest_valid", digest_valid, 1);
    check("digest", digest, ref_digest(p));
    check("busy_at_done", busy, 0);
    check("error_at_done", error, 0);
    @(negedge clk);
    check("digest_valid_pulse", digest_valid, 0);
    check("block_count", 256'(ctrl_log.size() - c0), 256'(nb));
    for (int k = 0; k < nb && c0 + k < ctrl_log.size(); k++) begin
      check("ctrl_value", ctrl_log[c0+k], k == 0 ? 32'h1 : 32'h2);
      check("block_words", blk_log[c0+k], ref_block(p, k));
    end
  endtask
  vec_t vt[8];
  initial begin
    wq_t m;
    logic [511:0] lb;
    int p0, d0, c0, t;
    vt[0] = '{1, 32'h61626364, 1, 32'h61626364, 32'h020};
    vt[1] = '{12, 32'h1000_0000, 1, 32'h1000_0000, 32'h180};
    vt[2] = '{13, 32'h2000_0000, 1, 32'h2000_0000, 32'h1a0};
    vt[3] = '{14, 32'h3000_0000, 2, 32'h0000_0000, 32'h1c0};
    vt[4] = '{15, 32'h4000_0000, 2, 32'h0000_0000, 32'h1e0};
    vt[5] = '{16, 32'h5000_0000, 2, 32'h8000_0000, 32'h200};
    vt[6] = '{20, 32'h1000_0000, 2, 32'h1000_0010, 32'h280};
    vt[7] = '{32, 32'h6000_0000, 3, 32'h8000_0000, 32'h400};
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hdead_beef;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_cs", bus.sha_cs, 0);
    check("rst_we", bus.sha_we, 0);
    check("rst_address", bus.sha_address, 0);
    check("rst_write_data", bus.sha_write_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("release_in_ready", in_ready, 1);
    for (int v = 0; v < 8; v++) begin
      m = {};
      for (int i = 0; i < vt[v].len; i++) m.push_back(vt[v].base + 32'(i));
      c0 = ctrl_log.size();
      run_msg(m, v % 3);
      lb = blk_log.size() > 0 ? blk_log[blk_log.size()-1] : '0;
      check("vec_blocks", 256'(ctrl_log.size() - c0), 256'(vt[v].blocks));
      check("vec_last_slot0", lb[511:480], vt[v].slot0);
      check("vec_last_slot15", lb[31:0], vt[v].slot15);
      if (vt[v].len == 1) check("vec_abcd_digest", digest, ABCD_DIGEST);
    end
    for (int r = 0; r < 12; r++) begin
      m = {};
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) m.push_back($urandom);
      run_msg(m, $urandom_range(0, 3));
    end
    hold_busy = 1'b1;
    p0 = poll_cnt;
    d0 = dv_cnt;
    m = '{32'h61626364};
    send_msg(m, 0, 1'b1);
    t = 0;
    while (!error && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    check("timeout_polls", 256'(poll_cnt - p0), 256'(1024));
    check("timeout_no_digest", 256'(dv_cnt - d0), 0);
    hold_busy = 1'b0;
    err_en = 1'b1;
    c0 = ctrl_log.size();
    m = '{32'h0, 32'h1, 32'h2, 32'h3};
    send_msg(m, 0, 1'b0);
    check("sha_error_flag", error, 1);
    check("sha_error_busy", busy, 0);
    check("sha_error_idle", in_ready, 1);
    check("sha_error_no_ctrl", 256'(ctrl_log.size() - c0), 0);
    err_en = 1'b0;
    m = '{32'h61626364};
    run_msg(m, 0);
    hold_busy = 1'b1;
    p0 = poll_cnt;
    send_msg(m, 0, 1'b1);
    t = 0;
    while (poll_cnt - p0 < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("poll_reached", busy, 1);
    reset_n = 1'b0;
    #1;
    check("poll_rst_busy", busy, 0);
    check("poll_rst_error", error, 0);
    check("poll_rst_digest", digest, 0);
    check("poll_rst_in_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("poll_rst_cs", bus.sha_cs, 0);
      check("poll_rst_address", bus.sha_address, 0);
    end
    reset_n = 1'b1;
    hold_busy = 1'b0;
    #1 check("poll_release_in_ready", in_ready, 1);
    @(negedge clk);
    run_msg(m, 0);
    check("after_reset_abcd", digest, ABCD_DIGEST);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
